// File: rtl/bus_sequencer_if.sv
// Control/handshake bundle between the bus sequencer and the single-bus datapath.
// master = sequencer side, slave = datapath side.
interface bus_sequencer_if #(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int OPW  = 3
);
    logic            start;
    logic            din_valid;
    logic            din_ready;
    logic [DW-1:0]   ir;
    logic [NREG-1:0] r_out;
    logic [NREG-1:0] r_in;
    logic            din_out;
    logic            ir_in;
    logic            a_in;
    logic            g_in;
    logic            g_out;
    logic            alu_en;
    logic [OPW-1:0]  alu_op;
    logic            busy;
    logic            done;

    modport master (
        input  start, din_valid, ir,
        output din_ready, r_out, r_in, din_out, ir_in, a_in,
               g_in, g_out, alu_en, alu_op, busy, done
    );

    modport slave (
        output start, din_valid, ir,
        input  din_ready, r_out, r_in, din_out, ir_in, a_in,
               g_in, g_out, alu_en, alu_op, busy, done
    );
endinterface

// File: rtl/bus_sequencer.sv
// Multi-cycle control sequencer for the 16-bit single-bus datapath: fetches into IR,
// decodes MV / MVI / ALU ops and issues one-hot bus-driver and register-load strobes.
module bus_sequencer #(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int OPW  = 3
) (
    input logic               clock,
    input logic               reset,
    bus_sequencer_if.master   bus
);
    localparam int RW = $clog2(NREG);

    typedef enum logic [2:0] {IDLE, FETCH, T1, T2, T3} state_t;

    state_t          state;
    logic [OPW-1:0]  op;
    logic [RW-1:0]   rx;
    logic [RW-1:0]   ry;
    logic [NREG-1:0] rx_hot;
    logic [NREG-1:0] ry_hot;
    logic            is_mv;
    logic            is_mvi;
    logic            is_alu;
    logic            unused_ir;

    logic [NREG-1:0] r_out_q;
    logic [NREG-1:0] r_in_q;
    logic            alu_en_q;
    logic            g_in_q;
    logic            g_out_q;
    logic [OPW-1:0]  alu_op_q;
    logic            done_q;
    logic            busy_q;

    assign op        = bus.ir[DW-1 -: OPW];
    assign rx        = bus.ir[DW-OPW-1 -: RW];
    assign ry        = bus.ir[DW-OPW-RW-1 -: RW];
    assign unused_ir = ^bus.ir[DW-OPW-2*RW-1:0];
    assign rx_hot    = NREG'(1) << rx;
    assign ry_hot    = NREG'(1) << ry;
    assign is_mv     = (op == OPW'(0));
    assign is_mvi    = (op == OPW'(1));
    assign is_alu    = !is_mv && !is_mvi;

    // T2/T3 strobes are registered on entry; IR is stable from T1 onward.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            r_out_q  <= '0;
            r_in_q   <= '0;
            alu_en_q <= 1'b0;
            g_in_q   <= 1'b0;
            g_out_q  <= 1'b0;
            alu_op_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            r_out_q  <= '0;
            r_in_q   <= '0;
            alu_en_q <= 1'b0;
            g_in_q   <= 1'b0;
            g_out_q  <= 1'b0;
            alu_op_q <= '0;
            done_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= FETCH;
                        busy_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (bus.din_valid) state <= T1;
                end
                T1: begin
                    if (is_mv || (is_mvi && bus.din_valid)) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (is_alu) begin
                        state    <= T2;
                        r_out_q  <= ry_hot;
                        alu_en_q <= 1'b1;
                        g_in_q   <= 1'b1;
                        alu_op_q <= op;
                    end
                end
                T2: begin
                    state   <= T3;
                    g_out_q <= 1'b1;
                    r_in_q  <= rx_hot;
                    done_q  <= 1'b1;
                end
                T3: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // IR is loaded at the FETCH->T1 edge, so T1 strobes must decode it combinationally.
    logic in_fetch;
    logic in_t1;

    assign in_fetch = (state == FETCH);
    assign in_t1    = (state == T1);

    always_comb begin
        bus.din_ready = in_fetch || (in_t1 && is_mvi);
        bus.din_out   = bus.din_ready && bus.din_valid;
        bus.ir_in     = in_fetch && bus.din_valid;
        bus.r_out     = r_out_q;
        bus.r_in      = r_in_q;
        bus.a_in      = 1'b0;
        bus.done      = done_q;
        if (in_t1) begin
            if (is_mv) begin
                bus.r_out = ry_hot;
                bus.r_in  = rx_hot;
                bus.done  = 1'b1;
            end else if (is_mvi) begin
                if (bus.din_valid) begin
                    bus.r_in = rx_hot;
                    bus.done = 1'b1;
                end
            end else begin
                bus.r_out = rx_hot;
                bus.a_in  = 1'b1;
            end
        end
    end

    assign bus.g_in   = g_in_q;
    assign bus.g_out  = g_out_q;
    assign bus.alu_en = alu_en_q;
    assign bus.alu_op = alu_op_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: directed scenarios plus random instruction stream, each
// cycle compared against the control-step sequence implied by the instruction set.
module tb_bus_sequencer;
    typedef struct packed {
        logic       din_ready;
        logic       din_out;
        logic       ir_in;
        logic [7:0] r_out;
        logic [7:0] r_in;
        logic       a_in;
        logic       g_in;
        logic       g_out;
        logic       alu_en;
        logic [2:0] alu_op;
        logic       busy;
        logic       done;
    } ctl_t;

    logic        clock;
    logic        reset;
    logic [15:0] din;
    logic [15:0] ir_reg;
    int          checks;
    int          passes;
    int          done_seen;
    int          n_instr;

    bus_sequencer_if #(.DW(16), .NREG(8), .OPW(3)) bus ();

    bus_sequencer #(.DW(16), .NREG(8), .OPW(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Datapath IR register: loads the DIN word when the sequencer strobes ir_in.
    always @(posedge clock) begin
        if (!reset) ir_reg <= '0;
        else if (bus.ir_in) ir_reg <= din;
    end
    assign bus.ir = ir_reg;

    task automatic cyc(input string tag, input ctl_t exp);
        ctl_t obs;
        int   drivers;
        @(negedge clock);
        obs.din_ready = bus.din_ready;
        obs.din_out   = bus.din_out;
        obs.ir_in     = bus.ir_in;
        obs.r_out     = bus.r_out;
        obs.r_in      = bus.r_in;
        obs.a_in      = bus.a_in;
        obs.g_in      = bus.g_in;
        obs.g_out     = bus.g_out;
        obs.alu_en    = bus.alu_en;
        obs.alu_op    = bus.alu_op;
        obs.busy      = bus.busy;
        obs.done      = bus.done;
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        drivers = $countones(obs.r_out) + int'(obs.din_out) + int'(obs.g_out);
        checks++;
        assert (drivers <= 1) passes++;
        else $error("FAIL %s_onehot observed=%0d expected<=1", tag, drivers);
        if (obs.done === 1'b1) done_seen++;
        @(posedge clock);
        #1;
    endtask

    // One instruction from its IDLE cycle (start=1) through its done step.
    task automatic run_instr(input string tag, input logic [15:0] word, input int fstall,
                             input int tstall, input int gap, input bit hold);
        ctl_t       e;
        logic [2:0] op;
        logic [2:0] rx;
        logic [2:0] ry;
        op = word[15:13];
        rx = word[12:10];
        ry = word[9:7];
        n_instr++;
        repeat (gap) begin
            bus.start = 1'b0; bus.din_valid = 1'($urandom); din = 16'($urandom);
            e = '0;
            cyc({tag, "_gap"}, e);
        end
        bus.start = 1'b1; bus.din_valid = 1'($urandom); din = 16'($urandom);
        e = '0;
        cyc({tag, "_idle"}, e);
        repeat (fstall) begin
            bus.start = hold ? 1'b1 : 1'($urandom); bus.din_valid = 1'b0; din = 16'($urandom);
            e = '0; e.din_ready = 1'b1; e.busy = 1'b1;
            cyc({tag, "_fstall"}, e);
        end
        bus.start = hold ? 1'b1 : 1'($urandom); bus.din_valid = 1'b1; din = word;
        e = '0; e.din_ready = 1'b1; e.din_out = 1'b1; e.ir_in = 1'b1; e.busy = 1'b1;
        cyc({tag, "_fetch"}, e);
        if (op == 3'd0) begin
            bus.start = hold ? 1'b1 : 1'($urandom); bus.din_valid = 1'($urandom);
            e = '0; e.r_out = 8'(1) << ry; e.r_in = 8'(1) << rx; e.done = 1'b1; e.busy = 1'b1;
            cyc({tag, "_mv_t1"}, e);
        end else if (op == 3'd1) begin
            repeat (tstall) begin
                bus.start = hold ? 1'b1 : 1'($urandom); bus.din_valid = 1'b0;
                e = '0; e.din_ready = 1'b1; e.busy = 1'b1;
                cyc({tag, "_mvi_stall"}, e);
            end
            bus.start = hold ? 1'b1 : 1'($urandom); bus.din_valid = 1'b1; din = 16'($urandom);
            e = '0; e.din_ready = 1'b1; e.din_out = 1'b1; e.r_in = 8'(1) << rx;
            e.done = 1'b1; e.busy = 1'b1;
            cyc({tag, "_mvi_t1"}, e);
        end else begin
            bus.start = hold ? 1'b1 : 1'($urandom); bus.din_valid = 1'($urandom);
            e = '0; e.r_out = 8'(1) << rx; e.a_in = 1'b1; e.busy = 1'b1;
            cyc({tag, "_alu_t1"}, e);
            bus.start = hold ? 1'b1 : 1'($urandom); bus.din_valid = 1'($urandom);
            e = '0; e.r_out = 8'(1) << ry; e.alu_en = 1'b1; e.g_in = 1'b1; e.alu_op = op;
            e.busy = 1'b1;
            cyc({tag, "_alu_t2"}, e);
            bus.start = hold ? 1'b1 : 1'($urandom); bus.din_valid = 1'($urandom);
            e = '0; e.g_out = 1'b1; e.r_in = 8'(1) << rx; e.done = 1'b1; e.busy = 1'b1;
            cyc({tag, "_alu_t3"}, e);
        end
    endtask

    initial begin
        ctl_t e;
        checks = 0; passes = 0; done_seen = 0; n_instr = 0;
        reset = 1'b0; bus.start = 1'b0; bus.din_valid = 1'b0; din = '0;
        @(posedge clock); #1;
        e = '0;
        cyc("reset_hold", e);
        reset = 1'b1;
        cyc("idle_after_reset", e);

        // Reset abandoning an ADD in T2.
        bus.start = 1'b1;
        cyc("abort_idle", e);
        bus.start = 1'b0; bus.din_valid = 1'b1; din = 16'h4380;
        e = '0; e.din_ready = 1'b1; e.din_out = 1'b1; e.ir_in = 1'b1; e.busy = 1'b1;
        cyc("abort_fetch", e);
        bus.din_valid = 1'b0;
        e = '0; e.r_out = 8'h01; e.a_in = 1'b1; e.busy = 1'b1;
        cyc("abort_t1", e);
        reset = 1'b0;
        e = '0; e.r_out = 8'h80; e.alu_en = 1'b1; e.g_in = 1'b1; e.alu_op = 3'b010; e.busy = 1'b1;
        cyc("abort_t2", e);
        e = '0;
        cyc("abort_after_reset", e);
        reset = 1'b1;
        cyc("abort_idle_again", e);

        run_instr("mv_r1_r2", 16'h0500, 0, 0, 1, 1'b0);
        run_instr("mvi_r3", 16'h2C00, 0, 2, 1, 1'b0);
        run_instr("add_r0_r7", 16'h4380, 0, 0, 1, 1'b0);
        run_instr("same_rx_ry", 16'hE480, 1, 0, 1, 1'b0);
        run_instr("held_a", 16'h0500, 0, 0, 1, 1'b1);
        run_instr("held_b", 16'h6680, 0, 0, 0, 1'b1);
        run_instr("held_c", 16'h2C00, 0, 1, 0, 1'b1);

        for (int i = 0; i < 1600; i++) begin
            run_instr("rnd", 16'($urandom), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), 1'($urandom));
        end

        bus.start = 1'b0; bus.din_valid = 1'b0;
        e = '0;
        cyc("final_idle", e);
        checks++;
        assert (done_seen == n_instr) passes++;
        else $error("FAIL done_count observed=%0d expected=%0d", done_seen, n_instr);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
